serial_half_sub: RTL and testbench

//  Bit-serial W-bit subtractor: computes A - B, LSB first, one bit per clock,

---
 rtl/serial_half_sub_pkg.sv | 13 +
 rtl/half_sub_cell.sv | 21 ++
 rtl/serial_half_sub.sv | 125 ++++++++++++
 tb/tb_serial_half_sub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_half_sub_pkg.sv
// Shared types and constants for the bit-serial half-subtractor datapath.
// Optional build macro used by this block: SERIAL_HALF_SUB_ADD_MODE_EN.
package serial_half_sub_pkg;

  localparam int unsigned SHS_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shs_state_t;

endpackage

// File: rtl/half_sub_cell.sv
// Half-subtractor cell (d = x^y, bo = ~x&y); with SERIAL_HALF_SUB_ADD_MODE_EN
// an `add` input switches bo to the half-adder carry (x&y).
module half_sub_cell (
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
  input  logic add,
`endif
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d = x ^ y;

`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
  assign bo = add ? (x & y) : (~x & y);
`else
  assign bo = ~x & y;
`endif

endmodule

// File: rtl/serial_half_sub.sv
// Bit-serial W-bit subtractor (A - B, LSB first, one bit per clock) with
// valid/ready on both sides. SERIAL_HALF_SUB_ADD_MODE_EN adds a `mode` port (1 = A + B).
module serial_half_sub
  import serial_half_sub_pkg::*;
#(
  parameter int unsigned W = SHS_W
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
  input  logic         mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         busy
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  shs_state_t       state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             d1;
  logic             bo1;
  logic             d_bit;
  logic             bo2;
  logic             bor_nxt;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
  logic             mode_q;
`endif

  // Two cascaded cells form one full-subtractor (or full-adder) bit slice.
  half_sub_cell u_cell0 (
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
    .add (mode_q),
`endif
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .d   (d1),
    .bo  (bo1)
  );

  half_sub_cell u_cell1 (
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
    .add (mode_q),
`endif
    .x   (d1),
    .y   (bor),
    .d   (d_bit),
    .bo  (bo2)
  );

  assign bor_nxt = bo1 | bo2;

  // Control FSM and datapath; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      bor       <= 1'b0;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            a_sh     <= a;
            b_sh     <= b;
            bor      <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
            mode_q   <= mode;
`endif
          end
        end
        SHIFT: begin
          diff <= {d_bit, diff[W-1:1]};
          a_sh <= {1'b0, a_sh[W-1:1]};
          b_sh <= {1'b0, b_sh[W-1:1]};
          bor  <= bor_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            borrow    <= bor_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_half_sub.sv
// Self-checking bench for serial_half_sub: directed corner cases plus random
// operands against a plain-arithmetic reference model.
module tb_serial_half_sub;
  import serial_half_sub_pkg::*;

  localparam int unsigned W = SHS_W;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
  logic         mode      = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_half_sub #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_diff"},      32'(diff),      32'd0);
    check({tag, "_borrow"},    32'(borrow),    32'd0);
  endtask

  // One full transaction: accept, W shift cycles, hold in DONE, hand-off.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_mode, input int hold, input bit glitch);
    logic [W:0]   full;
    logic [W-1:0] exp_d;
    logic         exp_b;
    if (op_mode) begin
      full  = {1'b0, op_a} + {1'b0, op_b};
      exp_d = full[W-1:0];
      exp_b = full[W];
    end else begin
      exp_d = W'(op_a - op_b);
      exp_b = (op_a < op_b);
    end

    check("accept_ready", 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
    mode     = op_mode;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    check("shift_busy",  32'(busy),     32'd1);
    check("shift_ready", 32'(in_ready), 32'd0);

    for (int i = 1; i < W; i++) begin
      if (glitch && i == 3) begin
        in_valid = 1'b1;
        a        = W'(32'h11);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("no_early_valid", 32'(out_valid), 32'd0);
    end

    @(posedge clk); #1;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("result_diff",   32'(diff),      32'(exp_d));
    check("result_borrow", 32'(borrow),    32'(exp_b));
    check("done_busy",     32'(busy),      32'd0);

    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid",  32'(out_valid), 32'd1);
      check("hold_ready",  32'(in_ready),  32'd0);
      check("hold_diff",   32'(diff),      32'(exp_d));
      check("hold_borrow", 32'(borrow),    32'(exp_b));
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready",  32'(in_ready),  32'd1);
    check("idle_valid",  32'(out_valid), 32'd0);
    check("idle_diff",   32'(diff),      32'(exp_d));
    check("idle_borrow", 32'(borrow),    32'(exp_b));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rm;

    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'h9C, 8'h47, 1'b0, 20, 1'b0);
    run_op(8'h42, 8'h24, 1'b0, 0, 1'b1);

    // Abort mid-SHIFT: reset must clear everything without waiting for a clock.
    a        = 8'h5A;
    b        = 8'h33;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_reset("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);

`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
    run_op(8'hF0, 8'h20, 1'b1, 0, 1'b0);
    run_op(8'hF0, 8'h20, 1'b0, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 10 == 0) ra = '0;
      if (n % 10 == 5) rb = '1;
      rm = 1'b0;
`ifdef SERIAL_HALF_SUB_ADD_MODE_EN
      rm = 1'($urandom_range(0, 1));
`endif
      run_op(ra, rb, rm, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
